// File: rtl/jsv_usb_gpx_cond.sv
// GPX pin conditioner: synchronises and debounces the raw USB host GPX status pin
// into a clean level for the GPX PIO, with rise/fall pulses and a saturating glitch count.
module jsv_usb_gpx_cond #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned GLITCH_W        = 8,
   parameter bit          RESET_LEVEL     = 1'b0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                gpx_raw,
   input  logic                glitch_clr,
   output logic                gpx_clean,
   output logic                rise_pulse,
   output logic                fall_pulse,
   output logic [GLITCH_W-1:0] glitch_count
);

   localparam int unsigned     CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;

   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   clean_q, clean_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic [GLITCH_W-1:0]    glitch_q, glitch_d;
   logic                   reject;

   // Plain flop chain; gpx_raw is not used anywhere else.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], gpx_raw};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // A candidate level must hold for DEBOUNCE_CYCLES consecutive samples; any
   // return to the current clean level throws the partial count away.
   always_comb begin
      cnt_d   = cnt_q;
      clean_d = clean_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      reject  = 1'b0;
      if (s == clean_q) begin
         cnt_d  = '0;
         reject = (cnt_q != '0);
      end else if (cnt_q == CNT_LAST) begin
         clean_d = s;
         cnt_d   = '0;
         rise_d  = s;
         fall_d  = ~s;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Clear wins over a same-cycle rejection; the count sticks at all-ones.
   always_comb begin
      glitch_d = glitch_q;
      if (glitch_clr) begin
         glitch_d = '0;
      end else if (reject && (glitch_q != '1)) begin
         glitch_d = glitch_q + GLITCH_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         clean_q  <= RESET_LEVEL;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         glitch_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         clean_q  <= clean_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         glitch_q <= glitch_d;
      end
   end

   assign gpx_clean    = clean_q;
   assign rise_pulse   = rise_q;
   assign fall_pulse   = fall_q;
   assign glitch_count = glitch_q;

endmodule

// File: tb/tb_jsv_usb_gpx_cond.sv
// Bench for jsv_usb_gpx_cond: sample-history model checked every cycle, plus
// hand-computed latency and glitch-count expectations for directed pin patterns.
module tb_jsv_usb_gpx_cond;

   localparam int SYNC = 2;
   localparam int DC   = 16;
   localparam int GW   = 8;

   logic          clk;
   logic          reset_n;
   logic          gpx_raw;
   logic          glitch_clr;
   logic          gpx_clean;
   logic          rise_pulse;
   logic          fall_pulse;
   logic [GW-1:0] glitch_count;

   int errors = 0;
   int checks = 0;
   int rise_cnt = 0;
   int fall_cnt = 0;

   jsv_usb_gpx_cond #(
      .SYNC_STAGES(SYNC),
      .DEBOUNCE_CYCLES(DC),
      .GLITCH_W(GW),
      .RESET_LEVEL(1'b0)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .gpx_raw(gpx_raw),
      .glitch_clr(glitch_clr),
      .gpx_clean(gpx_clean),
      .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse),
      .glitch_count(glitch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: s is gpx_raw seen SYNC edges late; a new level is accepted once the
   // last DC samples of s all differ from the clean level; a glitch is a sample
   // equal to the clean level that ends a run of differing samples.
   bit sq[SYNC];
   bit shist[$];
   bit m_clean, m_rise, m_fall;
   int m_glitch;

   always @(posedge clk or negedge reset_n) begin
      bit s_pre, all_diff, glitch_ev;
      if (!reset_n) begin
         for (int i = 0; i < SYNC; i++) sq[i] = 1'b0;
         shist.delete();
         m_clean  = 1'b0;
         m_rise   = 1'b0;
         m_fall   = 1'b0;
         m_glitch = 0;
      end else begin
         s_pre = sq[SYNC-1];
         for (int i = SYNC-1; i > 0; i--) sq[i] = sq[i-1];
         sq[0] = gpx_raw;
         shist.push_back(s_pre);
         if (shist.size() > DC+1) void'(shist.pop_front());
         all_diff = (shist.size() >= DC);
         for (int k = 0; k < DC && k < shist.size(); k++)
            if (shist[shist.size()-1-k] == m_clean) all_diff = 1'b0;
         glitch_ev = (s_pre == m_clean) && (shist.size() >= 2) &&
                     (shist[shist.size()-2] != m_clean);
         m_rise = 1'b0;
         m_fall = 1'b0;
         if (all_diff) begin
            m_clean = s_pre;
            m_rise  = s_pre;
            m_fall  = ~s_pre;
         end else if (glitch_ev && m_glitch < (1 << GW) - 1) begin
            m_glitch++;
         end
         if (glitch_clr) m_glitch = 0;
      end
   end

   always @(negedge clk) begin
      chk("gpx_clean", int'(gpx_clean), int'(m_clean));
      chk("rise_pulse", int'(rise_pulse), int'(m_rise));
      chk("fall_pulse", int'(fall_pulse), int'(m_fall));
      chk("glitch_count", int'(glitch_count), m_glitch);
      chk("pulse_exclusive", int'(rise_pulse & fall_pulse), 0);
      if (rise_pulse) rise_cnt++;
      if (fall_pulse) fall_cnt++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Returns the edge number (edge 1 = next edge) on which gpx_clean reaches
   // target, or -1 if it never does within the budget.
   task automatic wait_clean(input logic target, output int n);
      n = -1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (gpx_clean == target) begin
            n = e;
            return;
         end
      end
   endtask

   initial begin
      int n;
      int r0, f0;
      reset_n    = 1'b0;
      gpx_raw    = 1'b0;
      glitch_clr = 1'b0;
      #1;
      chk("por_clean", int'(gpx_clean), 0);
      chk("por_glitch", int'(glitch_count), 0);
      cyc(3);
      reset_n = 1'b1;
      cyc(3);

      // clean rise and fall at default parameters
      r0 = rise_cnt;
      gpx_raw = 1'b1;
      wait_clean(1'b1, n);
      chk("rise_latency", n, 18);
      chk("rise_coincident", int'(rise_pulse), 1);
      chk("rise_no_fall", int'(fall_pulse), 0);
      chk("rise_no_early_pulse", rise_cnt - r0, 0);
      cyc(1);
      chk("rise_one_cycle", int'(rise_pulse), 0);
      chk("rise_glitch", int'(glitch_count), 0);
      gpx_raw = 1'b0;
      wait_clean(1'b0, n);
      chk("fall_latency", n, 18);
      chk("fall_coincident", int'(fall_pulse), 1);
      cyc(1);
      chk("fall_one_cycle", int'(fall_pulse), 0);

      // bounce rejection: 5 and 15 cycles rejected, 16 accepted
      gpx_raw = 1'b1; cyc(5); gpx_raw = 1'b0; cyc(25);
      chk("bounce5_glitch", int'(glitch_count), 1);
      chk("bounce5_clean", int'(gpx_clean), 0);
      gpx_raw = 1'b1; cyc(15); gpx_raw = 1'b0; cyc(25);
      chk("bounce15_glitch", int'(glitch_count), 2);
      chk("bounce15_clean", int'(gpx_clean), 0);
      r0 = rise_cnt; f0 = fall_cnt;
      gpx_raw = 1'b1; cyc(16); gpx_raw = 1'b0; cyc(40);
      chk("accept16_rises", rise_cnt - r0, 1);
      chk("accept16_falls", fall_cnt - f0, 1);
      chk("accept16_glitch", int'(glitch_count), 2);

      // bounce then settle: 1,1,1,0 then steady 1
      gpx_raw = 1'b1; cyc(3); gpx_raw = 1'b0; cyc(1);
      r0 = rise_cnt;
      gpx_raw = 1'b1;
      wait_clean(1'b1, n);
      chk("settle_latency", n, 18);
      chk("settle_no_early_pulse", rise_cnt - r0, 0);
      chk("settle_glitch", int'(glitch_count), 3);

      // asynchronous reset with gpx_raw high and gpx_clean high
      cyc(1);
      reset_n = 1'b0;
      #1;
      chk("async_rst_clean", int'(gpx_clean), 0);
      chk("async_rst_rise", int'(rise_pulse), 0);
      chk("async_rst_fall", int'(fall_pulse), 0);
      chk("async_rst_glitch", int'(glitch_count), 0);
      cyc(2);
      reset_n = 1'b1;
      r0 = rise_cnt;
      wait_clean(1'b1, n);
      chk("post_rst_latency", n, 18);
      chk("post_rst_no_early_pulse", rise_cnt - r0, 0);

      // reset while a candidate is at cnt=10
      cyc(1);
      gpx_raw = 1'b0;
      wait_clean(1'b0, n);
      chk("midq_prep_fall", n, 18);
      cyc(1);
      gpx_raw = 1'b1;
      cyc(12);
      reset_n = 1'b0;
      cyc(1);
      reset_n = 1'b1;
      chk("midq_clean_after_release", int'(gpx_clean), 0);
      r0 = rise_cnt;
      wait_clean(1'b1, n);
      chk("midq_latency", n, 18);
      chk("midq_no_early_pulse", rise_cnt - r0, 0);

      // saturation and clear priority
      cyc(1);
      gpx_raw = 1'b0;
      wait_clean(1'b0, n);
      cyc(1);
      for (int i = 0; i < 300; i++) begin
         gpx_raw = 1'b1; cyc(1); gpx_raw = 1'b0; cyc(3);
      end
      chk("saturate_255", int'(glitch_count), 255);
      chk("saturate_clean", int'(gpx_clean), 0);
      gpx_raw = 1'b1; cyc(1); gpx_raw = 1'b0; cyc(2);
      glitch_clr = 1'b1; cyc(1); glitch_clr = 1'b0;
      chk("clr_beats_inc", int'(glitch_count), 0);
      cyc(3);
      gpx_raw = 1'b1; cyc(1); gpx_raw = 1'b0; cyc(4);
      chk("count_after_clr", int'(glitch_count), 1);

      cyc(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
